uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, the counterpart of the team's 16x-oversampled uart_tx. It shares the same baud `tick` generator.
- Synchronises the asynchronous serial input.
- Detects and validates the start bit, then samples each data bit at mid-bit, LSB first.
- Checks the stop bit.
- Presents each received byte through a one-entry valid/ready holding register, with sticky framing and overrun error flags.

Parameters:
DBIT, 8, number of data bits per frame (5..9)
SB_TICK, 16, oversample ticks spent in stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2)
SYNC_STAGES, 2, flops in the rx input synchroniser (>=2)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
tick  input  1  baud oversample strobe, 16 per bit period, one clk wide
rx  input  1  asynchronous serial line, idle high
dout  output  DBIT  received data, stable while rx_valid=1
rx_valid  output  1  dout holds an unconsumed byte
rx_ready  input  1  consumer accepts dout when rx_valid & rx_ready
rx_done_tick  output  1  one-clk pulse at end of every frame, good or bad
frame_err  output  1  sticky: a stop bit was sampled low
overrun  output  1  sticky: a good frame arrived while rx_valid=1 and not consumed
clear_err  input  1  clears frame_err and overrun

Behaviour:
Reset (asynchronous, any state, including mid-frame):
- Synchroniser flops = 1; state = idle; counters = 0.
- dout = 0; rx_valid = 0; rx_done_tick = 0; frame_err = 0; overrun = 0.

Input path:
- rx_s is the output of the SYNC_STAGES-flop synchroniser. rx is never used directly.

State machine (states idle, start, data, stop):
- The tick counter (4 bit, widened to cover SB_TICK-1) and the bit index (clog2(DBIT)) advance only on cycles with tick=1.
- idle: on tick with rx_s=0 -> start, tick_cnt=0.
- start: on tick, tick_cnt increments.
  - At tick_cnt==7 (mid start bit): if rx_s=0 -> data, tick_cnt=0, idx=0.
  - If rx_s=1 at that point, it is a false start (glitch) -> idle, with no pulse and no flag.
- data: on tick with tick_cnt==15:
  - Shift rx_s into the MSB of shift register sr (right shift, so the LSB arrives first).
  - tick_cnt=0.
  - If idx==DBIT-1 -> stop; else idx+1.
- stop: on tick with tick_cnt==SB_TICK-1:
  - Sample rx_s, go to idle.
  - Register rx_done_tick=1 for exactly the next clk.
- Frame complete, rx_s=1 (good frame):
  - If rx_valid=0, or rx_valid & rx_ready in the same cycle: dout<=sr, rx_valid<=1.
  - Else: overrun<=1. The new byte is dropped and dout is unchanged.
- Frame complete, rx_s=0 (bad stop bit): frame_err<=1. dout and rx_valid are unchanged.

Handshake and flags:
- rx_valid & rx_ready with no simultaneous load -> rx_valid<=0.
- clear_err=1 clears both sticky flags. A flag set in the same cycle as clear_err wins (the flag stays 1).

Boundary conditions and timing:
- A new start bit is accepted in the first idle tick after stop. No extra gap is required.
- Latency: dout and rx_valid update on the same clk edge that raises rx_done_tick.
  - That edge is one clk after the final stop tick.
  - The final stop tick falls ≈(SB_TICK-8) ticks into the stop bit, i.e. at mid-stop-bit for the default SB_TICK=16.
- All counters wrap only under FSM control. tick_cnt never exceeds SB_TICK-1.
- With tick=0 the FSM holds. A tick tied high is legal (oversampling at clk rate).

Decomposition:
- Package uart_pkg:
  - typedef enum uart_state_t {idle, start, data, stop}, shared with uart_tx.
  - localparam OSR=16.
  - localparam MID_TICK=7.
- Sub-module uart_sync: a generic SYNC_STAGES-flop synchroniser with an asynchronous reset value parameter (here 1). It is reusable for the uart_tx clear-to-send path later.

Test Plan:
- Frame 0xA5, 8N1, tick every 4 clk, rx_ready=0 -> one rx_done_tick, dout=0xA5, rx_valid=1 held, frame_err=0; then rx_ready=1 for 1 clk -> rx_valid=0.
- rx low for 4 ticks then high (glitch) -> FSM returns to idle, no rx_done_tick, no flags, dout unchanged; a following 0x3C frame -> dout=0x3C.
- Frame 0x5A with stop bit driven 0 -> rx_done_tick pulses, frame_err=1, rx_valid stays 0; clear_err -> frame_err=0.
- Frames 0x11 then 0x22 back-to-back, rx_ready=0 -> dout=0x11, overrun=1; repeat with rx_ready=1 asserted on the 0x22 completion cycle -> dout=0x22, overrun=0.
- rst asserted mid data bit 3, then 0xF0 sent -> all outputs 0 during reset, clean reception of 0xF0 afterward.
- tick=1 every clk, DBIT=7, SB_TICK=32, frame 0x7F followed immediately by 0x00 -> both received, no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants
// used by both the receiver and transmitter.
package uart_pkg;

  localparam int OSR      = 16;
  localparam int MID_TICK = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Generic multi-flop synchroniser for a single asynchronous bit, with a
// configurable reset value so an idle-high line does not glitch out of reset.
module uart_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with a one-entry valid/ready output register
// and sticky framing / overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT        = 8,
  parameter int SB_TICK     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            overrun,
  input  logic            clear_err
);

  localparam int TW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int IW = $clog2(DBIT);

  localparam logic [TW-1:0] MID_LAST  = TW'(MID_TICK);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OSR - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DBIT - 1);

  logic rx_s;

  uart_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  uart_state_t     state_q;
  logic [TW-1:0]   tick_cnt_q;
  logic [IW-1:0]   idx_q;
  logic [DBIT-1:0] sr_q;
  logic [DBIT-1:0] dout_q;
  logic            valid_q;
  logic            done_q;
  logic            ferr_q;
  logic            ovr_q;

  // Frame completion is decided on the final stop tick; the stop bit level
  // at that instant selects the good/bad path.
  logic frame_end;
  logic frame_good;
  logic frame_bad;
  logic can_load;
  logic load;
  logic drop;

  assign frame_end  = tick && (state_q == STOP) && (tick_cnt_q == STOP_LAST);
  assign frame_good = frame_end && rx_s;
  assign frame_bad  = frame_end && !rx_s;
  assign can_load   = !valid_q || rx_ready;
  assign load       = frame_good && can_load;
  assign drop       = frame_good && !can_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      idx_q      <= '0;
      sr_q       <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tick) begin
        unique case (state_q)
          IDLE: begin
            if (!rx_s) begin
              state_q    <= START;
              tick_cnt_q <= '0;
            end
          end
          START: begin
            if (tick_cnt_q == MID_LAST) begin
              tick_cnt_q <= '0;
              if (!rx_s) begin
                state_q <= DATA;
                idx_q   <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
          DATA: begin
            if (tick_cnt_q == BIT_LAST) begin
              sr_q       <= {rx_s, sr_q[DBIT-1:1]};
              tick_cnt_q <= '0;
              if (idx_q == IDX_LAST) begin
                state_q <= STOP;
              end else begin
                idx_q <= idx_q + IW'(1);
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
          STOP: begin
            if (tick_cnt_q == STOP_LAST) begin
              state_q    <= IDLE;
              tick_cnt_q <= '0;
              done_q     <= 1'b1;
            end else begin
              tick_cnt_q <= tick_cnt_q + TW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end

      // A consume and a load in the same cycle leave valid set with new data.
      if (load) begin
        dout_q  <= sr_q;
        valid_q <= 1'b1;
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end

      if (clear_err) ferr_q <= 1'b0;
      if (frame_bad) ferr_q <= 1'b1;
      if (clear_err) ovr_q  <= 1'b0;
      if (drop)      ovr_q  <= 1'b1;
    end
  end

  assign dout         = dout_q;
  assign rx_valid     = valid_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes the expected post-frame
// output state, monitors pop and compare on every rx_done_tick.
module tb_uart_rx;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic       fe;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] dout;
  logic       rx_valid, rx_done_tick, frame_err, overrun;

  logic       tick2 = 1'b1;
  logic       rx2 = 1'b1;
  logic       rx_ready2 = 1'b0;
  logic       clear_err2 = 1'b0;
  logic [6:0] dout2;
  logic       rx_valid2, done2, ferr2, ovr2;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   start_cyc = 0;
  exp_t q1[$];
  exp_t q2[$];

  uart_rx #(.DBIT(8), .SB_TICK(16), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .rx           (rx),
    .dout         (dout),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .clear_err    (clear_err)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32), .SYNC_STAGES(2)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick2),
    .rx           (rx2),
    .dout         (dout2),
    .rx_valid     (rx_valid2),
    .rx_ready     (rx_ready2),
    .rx_done_tick (done2),
    .frame_err    (ferr2),
    .overrun      (ovr2),
    .clear_err    (clear_err2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One tick every fourth clock for the 8N1 instance
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  function automatic exp_t mk(input logic [7:0] d, input logic v,
                              input logic fe, input logic ov);
    exp_t e;
    e.d  = d;
    e.v  = v;
    e.fe = fe;
    e.ov = ov;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 1) rx = v;
    else rx2 = v;
  endtask

  task automatic send_frame(input int which, input logic [7:0] data,
                            input int nbits, input logic stop_val,
                            input int stop_clks, input int cpb);
    set_line(which, 1'b0);
    start_cyc = cyc;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      set_line(which, data[i]);
      repeat (cpb) @(negedge clk);
    end
    set_line(which, stop_val);
    repeat (stop_clks) @(negedge clk);
    set_line(which, 1'b1);
  endtask

  task automatic pulse_ready;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rx_done_tick) begin
      done_cnt++;
      done_cyc = cyc;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done1: got dout=%h valid=%b with no frame expected",
                 dout, rx_valid);
      end else begin
        e = q1.pop_front();
        chk("frame1 {dout,valid,ferr,ovr}",
            32'({dout, rx_valid, frame_err, overrun}), 32'(e));
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (done2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done2: got dout=%h valid=%b with no frame expected",
                 dout2, rx_valid2);
      end else begin
        e = q2.pop_front();
        chk("frame2 {dout,valid,ferr,ovr}",
            32'({1'b0, dout2, rx_valid2, ferr2, ovr2}), 32'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n0;
    int k;
    int lat;
    int target;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({dout, rx_valid, rx_done_tick, frame_err, overrun}), 32'd0);
    chk("reset_outputs2", 32'({dout2, rx_valid2, done2, ferr2, ovr2}), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 0xA5 held until consumed
    q1.push_back(mk(8'hA5, 1'b1, 1'b0, 1'b0));
    send_frame(1, 8'hA5, 8, 1'b1, 64, 64);
    repeat (16) @(negedge clk);
    chk("hold_valid {valid,dout}", 32'({rx_valid, dout}), 32'({1'b1, 8'hA5}));
    pulse_ready();
    chk("ready_drop", 32'(rx_valid), 32'd0);

    // False start: low for four ticks only
    n0 = done_cnt;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_no_done", 32'(done_cnt), 32'(n0));
    chk("glitch_state {valid,ferr,ovr,dout}",
        32'({rx_valid, frame_err, overrun, dout}), 32'({3'b000, 8'hA5}));
    q1.push_back(mk(8'h3C, 1'b1, 1'b0, 1'b0));
    send_frame(1, 8'h3C, 8, 1'b1, 64, 64);
    repeat (16) @(negedge clk);
    pulse_ready();

    // Bad stop bit
    q1.push_back(mk(8'h3C, 1'b0, 1'b1, 1'b0));
    send_frame(1, 8'h5A, 8, 1'b0, 44, 64);
    repeat (100) @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("clear_ferr", 32'(frame_err), 32'd0);

    // Back-to-back with nobody consuming: second byte dropped
    q1.push_back(mk(8'h11, 1'b1, 1'b0, 1'b0));
    q1.push_back(mk(8'h11, 1'b1, 1'b0, 1'b1));
    send_frame(1, 8'h11, 8, 1'b1, 64, 64);
    send_frame(1, 8'h22, 8, 1'b1, 64, 64);
    repeat (16) @(negedge clk);
    rx_ready = 1'b1;
    clear_err = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    clear_err = 1'b0;
    chk("consume_clear {valid,ovr}", 32'({rx_valid, overrun}), 32'd0);

    // Back-to-back with the consume landing on the 0x22 load edge
    q1.push_back(mk(8'h11, 1'b1, 1'b0, 1'b0));
    q1.push_back(mk(8'h22, 1'b1, 1'b0, 1'b0));
    fork
      begin
        send_frame(1, 8'h11, 8, 1'b1, 64, 64);
        send_frame(1, 8'h22, 8, 1'b1, 64, 64);
      end
      begin
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < 2000) begin
          @(negedge clk);
          k++;
        end
        if (done_cnt == n0) begin
          checks++;
          errors++;
          $display("FAIL done_wait: got no rx_done_tick within %0d clks, required one", k);
        end else begin
          lat = done_cyc - start_cyc;
          target = start_cyc + 640 + lat - 1;
          while (cyc < target) @(negedge clk);
          rx_ready = 1'b1;
          @(negedge clk);
          rx_ready = 1'b0;
        end
      end
    join
    repeat (16) @(negedge clk);
    chk("same_cycle_load {valid,ovr,dout}", 32'({rx_valid, overrun, dout}),
        32'({1'b1, 1'b0, 8'h22}));

    // Reset in the middle of data bit 3 of 0xF0 (bits 0..3 are all low)
    rx = 1'b0;
    repeat (64 + 3 * 64 + 32) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_mid_frame", 32'({dout, rx_valid, rx_done_tick, frame_err, overrun}), 32'd0);
    rst = 1'b0;
    rx = 1'b1;
    repeat (100) @(negedge clk);
    q1.push_back(mk(8'hF0, 1'b1, 1'b0, 1'b0));
    send_frame(1, 8'hF0, 8, 1'b1, 64, 64);
    repeat (16) @(negedge clk);
    pulse_ready();

    // 7 data bits, two stop bits, tick every clock
    rx_ready2 = 1'b1;
    q2.push_back(mk(8'h7F, 1'b1, 1'b0, 1'b0));
    q2.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0));
    send_frame(2, 8'h7F, 7, 1'b1, 32, 16);
    send_frame(2, 8'h00, 7, 1'b1, 32, 16);
    repeat (50) @(negedge clk);
    chk("dut2_flags {ferr,ovr}", 32'({ferr2, ovr2}), 32'd0);

    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
